// File: rtl/ioexp_in_filter.sv
`default_nettype none
// ============================================================================
// Module   : ioexp_in_filter
// Purpose  : Input conditioning for the 16-bit word read back from a
//            PCAL6416A I/O expander. Debounces every bit across successive
//            readbacks, latches sticky rise/fall events with per-bit irq
//            enables, and flags stale data when readbacks stop arriving.
// Ports    :
//   clk           in   1   system clock
//   reset         in   1   synchronous, active-high reset
//   sample        in   16  readback word from the expander controller
//   sample_valid  in   1   1-cycle strobe, sample holds a new readback
//   rise_en       in   16  per-bit enable of rise events into irq
//   fall_en       in   16  per-bit enable of fall events into irq
//   clr           in   16  per-bit clear mask for the sticky flags
//   clr_valid     in   1   1-cycle strobe, apply clr
//   level         out  16  debounced input levels
//   level_valid   out  1   high once the first sample has been taken
//   rise          out  16  sticky debounced 0->1 events
//   fall          out  16  sticky debounced 1->0 events
//   irq           out  1   OR of enabled sticky events
//   stale         out  1   no sample_valid for STALE_CYCLES cycles
// Revision : 1.0  initial release
// ============================================================================
module ioexp_in_filter #(
    parameter int          DEBOUNCE_SAMPLES = 3,
    parameter int          STALE_CYCLES     = 2**24,
    parameter int          STALE_BITS       = 25,
    parameter logic [15:0] INIT_LEVEL       = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] sample,
    input  logic        sample_valid,
    input  logic [15:0] rise_en,
    input  logic [15:0] fall_en,
    input  logic [15:0] clr,
    input  logic        clr_valid,
    output logic [15:0] level,
    output logic        level_valid,
    output logic [15:0] rise,
    output logic [15:0] fall,
    output logic        irq,
    output logic        stale
);

    localparam int                 c_cnt_w    = $clog2(DEBOUNCE_SAMPLES + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_SAMPLES - 1);

    logic [15:0] r_level;
    logic        r_level_valid;
    logic [15:0] r_rise;
    logic [15:0] r_fall;

    logic [15:0] w_diff;
    logic [15:0] w_flip;
    logic [15:0] w_clr;
    logic        w_debounce;

    // Debouncing only starts once a reference level exists; the first
    // sample is loaded verbatim instead.
    assign w_debounce = r_level_valid && sample_valid;
    assign w_diff     = sample ^ r_level;
    assign w_clr      = clr_valid ? clr : 16'h0000;

    // ------------------------------------------------------------------
    // Per-bit run counters: count consecutive samples that disagree with
    // the current level; the bit flips on the DEBOUNCE_SAMPLES-th one.
    // ------------------------------------------------------------------
    for (genvar i = 0; i < 16; i++) begin : g_bit
        logic [c_cnt_w-1:0] r_cnt;

        assign w_flip[i] = w_debounce && w_diff[i] && (r_cnt == c_cnt_last);

        always_ff @(posedge clk) begin
            if (reset) begin
                r_cnt <= '0;
            end else if (w_debounce) begin
                if (!w_diff[i] || w_flip[i]) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Level and sticky event flags. A new event on a bit overrides a
    // clear arriving on that same bit in the same cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_level       <= INIT_LEVEL;
            r_level_valid <= 1'b0;
            r_rise        <= 16'h0000;
            r_fall        <= 16'h0000;
        end else begin
            if (sample_valid && !r_level_valid) begin
                r_level       <= sample;
                r_level_valid <= 1'b1;
            end else begin
                r_level <= r_level ^ w_flip;
            end
            r_rise <= (r_rise & ~w_clr) | (w_flip & ~r_level);
            r_fall <= (r_fall & ~w_clr) | (w_flip &  r_level);
        end
    end

    // ------------------------------------------------------------------
    // Readback watchdog: counts idle cycles, saturating at STALE_CYCLES.
    // ------------------------------------------------------------------
    if (STALE_CYCLES > 0) begin : g_wd
        localparam logic [STALE_BITS-1:0] c_stale_max = STALE_BITS'(STALE_CYCLES);

        logic [STALE_BITS-1:0] r_wd_cnt;
        logic                  r_stale;

        always_ff @(posedge clk) begin
            if (reset) begin
                r_wd_cnt <= '0;
                r_stale  <= 1'b0;
            end else if (sample_valid) begin
                r_wd_cnt <= '0;
                r_stale  <= 1'b0;
            end else if (r_wd_cnt != c_stale_max) begin
                r_wd_cnt <= r_wd_cnt + 1'b1;
                // Stale tracks the counter's new value so it rises on the
                // same edge the counter reaches saturation.
                r_stale  <= ((r_wd_cnt + 1'b1) == c_stale_max);
            end
        end

        assign stale = r_stale;
    end else begin : g_no_wd
        assign stale = 1'b0;
    end

    assign level       = r_level;
    assign level_valid = r_level_valid;
    assign rise        = r_rise;
    assign fall        = r_fall;
    assign irq         = |((r_rise & rise_en) | (r_fall & fall_en));

endmodule
`default_nettype wire
